// File: rtl/conv_result_checker_pkg.sv
// Shared definitions for the convolution result checker: FSM encoding,
// engine/output geometry and the capture-buffer index mapping.
package conv_result_checker_pkg;

    localparam int NUM_OUT   = 4;
    localparam int NUM_ENG   = 3;
    localparam int NUM_BYTES = NUM_OUT * NUM_ENG;

    localparam int ENG_SINGLE = 0;
    localparam int ENG_SYS3   = 1;
    localparam int ENG_SYS2   = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } chk_state_t;

    // Bytes arrive engine-major: all outputs of one engine, then the next engine.
    function automatic int buf_idx(input int eng, input int out);
        return eng * NUM_OUT + out;
    endfunction

endpackage

// File: rtl/conv_result_checker_result_compare.sv
// Combinational cross-check of both systolic engines against the single-MAC
// engine over the captured result bytes.
module result_compare
    import conv_result_checker_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0]  buffer [NUM_BYTES],
    output logic [NUM_OUT-1:0] agree,
    output logic [NUM_OUT-1:0] sys3_err,
    output logic [NUM_OUT-1:0] sys2_err,
    output logic [2:0]         err_count
);

    always_comb begin
        agree     = '0;
        sys3_err  = '0;
        sys2_err  = '0;
        err_count = '0;
        for (int j = 0; j < NUM_OUT; j++) begin
            sys3_err[j] = buffer[buf_idx(ENG_SYS3, j)] != buffer[buf_idx(ENG_SINGLE, j)];
            sys2_err[j] = buffer[buf_idx(ENG_SYS2, j)] != buffer[buf_idx(ENG_SINGLE, j)];
            // Both systolic engines matching the reference implies all three match.
            agree[j]    = !(sys3_err[j] || sys2_err[j]);
            if (!agree[j]) begin
                err_count = err_count + 3'd1;
            end
        end
    end

endmodule

// File: rtl/conv_result_checker.sv
// Captures the 12-byte serial result stream a fixed latency after run,
// cross-checks the engines and exposes a registered read port into the buffer.
module conv_result_checker
    import conv_result_checker_pkg::*;
#(
    parameter int DATA_W        = 8,
    parameter int CAPTURE_DELAY = 114
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    input  logic [DATA_W-1:0]  display_result,
    input  logic [3:0]         rd_addr,
    output logic [DATA_W-1:0]  rd_data,
    output logic               done,
    output logic [NUM_OUT-1:0] agree,
    output logic [NUM_OUT-1:0] sys3_err,
    output logic [NUM_OUT-1:0] sys2_err,
    output logic [2:0]         err_count,
    output logic [1:0]         chk_state
);

    localparam int                CNT_W    = $clog2(CAPTURE_DELAY);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CAPTURE_DELAY - 1);
    localparam logic [3:0]        IDX_LAST = 4'(NUM_BYTES - 1);

    chk_state_t        state;
    chk_state_t        state_next;
    logic [CNT_W-1:0]  cnt;
    logic [3:0]        cap_idx;
    logic [DATA_W-1:0] buffer [NUM_BYTES];
    logic [DATA_W-1:0] rd_next;

    logic arm;
    logic cap_we;
    logic cmp_load;

    logic [NUM_OUT-1:0] cmp_agree;
    logic [NUM_OUT-1:0] cmp_sys3_err;
    logic [NUM_OUT-1:0] cmp_sys2_err;
    logic [2:0]         cmp_err_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:    if (run) state_next = ST_WAIT;
            ST_WAIT:    if (cnt == CNT_LAST) state_next = ST_CAPTURE;
            ST_CAPTURE: if (cap_idx == IDX_LAST) state_next = ST_DONE;
            ST_DONE:    if (run) state_next = ST_WAIT;
            default:    state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        arm       = 1'b0;
        cap_we    = 1'b0;
        cmp_load  = 1'b0;
        chk_state = state;
        case (state)
            ST_IDLE:    arm = run;
            ST_CAPTURE: cap_we = 1'b1;
            ST_DONE: begin
                arm      = run;
                // Buffer is frozen in DONE, so reloading every cycle just holds.
                cmp_load = !run;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            cap_idx   <= '0;
            done      <= 1'b0;
            agree     <= '0;
            sys3_err  <= '0;
            sys2_err  <= '0;
            err_count <= '0;
            for (int i = 0; i < NUM_BYTES; i++) buffer[i] <= '0;
        end else if (arm) begin
            cnt       <= CNT_W'(1);
            cap_idx   <= '0;
            done      <= 1'b0;
            agree     <= '0;
            sys3_err  <= '0;
            sys2_err  <= '0;
            err_count <= '0;
            for (int i = 0; i < NUM_BYTES; i++) buffer[i] <= '0;
        end else if (state == ST_WAIT) begin
            cnt     <= cnt + CNT_W'(1);
            cap_idx <= '0;
        end else if (cap_we) begin
            for (int i = 0; i < NUM_BYTES; i++) begin
                if (cap_idx == 4'(i)) buffer[i] <= display_result;
            end
            cap_idx <= cap_idx + 4'd1;
        end else if (cmp_load) begin
            done      <= 1'b1;
            agree     <= cmp_agree;
            sys3_err  <= cmp_sys3_err;
            sys2_err  <= cmp_sys2_err;
            err_count <= cmp_err_count;
        end
    end

    // Out-of-range addresses match no entry and read as zero.
    always_comb begin
        rd_next = '0;
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (rd_addr == 4'(i)) rd_next = buffer[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= '0;
        end else begin
            rd_data <= rd_next;
        end
    end

    result_compare #(
        .DATA_W(DATA_W)
    ) u_compare (
        .buffer   (buffer),
        .agree    (cmp_agree),
        .sys3_err (cmp_sys3_err),
        .sys2_err (cmp_sys2_err),
        .err_count(cmp_err_count)
    );

endmodule

// File: tb/tb_conv_result_checker.sv
// Bench for conv_result_checker: table vectors, hand-written corner sequences
// and randomized streams checked against an engine-level reference model.
module tb_conv_result_checker;

    logic       clk = 1'b0;
    logic       reset;
    logic       run;
    logic [7:0] display_result;
    logic [3:0] rd_addr;
    logic [7:0] rd_data;
    logic       done;
    logic [3:0] agree;
    logic [3:0] sys3_err;
    logic [3:0] sys2_err;
    logic [2:0] err_count;
    logic [1:0] chk_state;

    conv_result_checker dut (
        .clk           (clk),
        .reset         (reset),
        .run           (run),
        .display_result(display_result),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .done          (done),
        .agree         (agree),
        .sys3_err      (sys3_err),
        .sys2_err      (sys2_err),
        .err_count     (err_count),
        .chk_state     (chk_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0][7:0] b;
        logic [3:0]       agree;
        logic [3:0]       s3;
        logic [3:0]       s2;
        int               cnt;
    } vec_t;

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] exp_q[$];
    logic [7:0] cur_bytes [12];
    logic [7:0] nom [4];
    vec_t       vecs [5];
    logic [3:0] e_agree;
    logic [3:0] e_s3;
    logic [3:0] e_s2;
    int         e_cnt;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Reference: view the stream as three engines x four outputs and compare engines.
    function automatic void model();
        logic [7:0] eng [3][4];
        for (int e = 0; e < 3; e++)
            for (int j = 0; j < 4; j++)
                eng[e][j] = cur_bytes[e * 4 + j];
        e_cnt = 0;
        for (int j = 0; j < 4; j++) begin
            e_s3[j]    = (eng[1][j] != eng[0][j]);
            e_s2[j]    = (eng[2][j] != eng[0][j]);
            e_agree[j] = (eng[0][j] == eng[1][j]) && (eng[0][j] == eng[2][j]);
            if (!e_agree[j]) e_cnt = e_cnt + 1;
        end
    endfunction

    task automatic do_run(input bit pulse_wait, input bit ff_before);
        run = 1'b1;
        step();                                   // edge E0
        run = 1'b0;
        check("arm_state", 32'(chk_state), 32'd1);
        check("arm_done", 32'(done), 32'd0);
        check("arm_agree_clr", 32'(agree), 32'd0);
        for (int i = 1; i <= 113; i++) begin
            display_result = (ff_before && i == 113) ? 8'hFF : 8'($urandom);
            run = pulse_wait && (i == 50);
            step();                               // edge E0+i
        end
        run = 1'b0;
        check("cap_start_state", 32'(chk_state), 32'd2);
        for (int k = 0; k < 12; k++) begin
            display_result = cur_bytes[k];
            step();                               // edge E0+114+k
        end
        check("done_state", 32'(chk_state), 32'd3);
        check("done_not_early", 32'(done), 32'd0);
        display_result = 8'($urandom);
        step();                                   // edge E0+126
        check("done", 32'(done), 32'd1);
        check("agree", 32'(agree), 32'(e_agree));
        check("sys3_err", 32'(sys3_err), 32'(e_s3));
        check("sys2_err", 32'(sys2_err), 32'(e_s2));
        check("err_count", 32'(err_count), 32'(e_cnt));
        for (int a = 0; a < 14; a++) begin
            rd_addr = 4'(a);
            exp_q.push_back(a < 12 ? cur_bytes[a] : 8'h00);
            display_result = 8'($urandom);
            step();
            check("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
        end
        check("done_hold", 32'(done), 32'd1);
        check("agree_hold", 32'(agree), 32'(e_agree));
    endtask

    initial begin
        reset          = 1'b1;
        run            = 1'b0;
        display_result = 8'h00;
        rd_addr        = 4'd0;
        nom = '{8'd110, 8'd101, 8'd110, 8'd121};

        for (int v = 0; v < 5; v++)
            for (int k = 0; k < 12; k++)
                vecs[v].b[k] = nom[k % 4];
        vecs[0].agree = 4'b1111; vecs[0].s3 = 4'b0000; vecs[0].s2 = 4'b0000; vecs[0].cnt = 0;
        vecs[1].b[9]  = 8'd102;
        vecs[1].agree = 4'b1101; vecs[1].s3 = 4'b0000; vecs[1].s2 = 4'b0010; vecs[1].cnt = 1;
        for (int k = 0; k < 12; k++) vecs[2].b[k] = 8'd11;
        vecs[2].agree = 4'b1111; vecs[2].s3 = 4'b0000; vecs[2].s2 = 4'b0000; vecs[2].cnt = 0;
        vecs[3].b[6]  = 8'd7;
        vecs[3].b[11] = 8'd9;
        vecs[3].agree = 4'b0011; vecs[3].s3 = 4'b0100; vecs[3].s2 = 4'b1000; vecs[3].cnt = 2;
        for (int j = 0; j < 4; j++) begin
            vecs[4].b[4 + j] = nom[j] + 8'd1;
            vecs[4].b[8 + j] = nom[j] + 8'd1;
        end
        vecs[4].agree = 4'b0000; vecs[4].s3 = 4'b1111; vecs[4].s2 = 4'b1111; vecs[4].cnt = 4;

        step();
        step();
        check("rst_state", 32'(chk_state), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_agree", 32'(agree), 32'd0);
        check("rst_sys3", 32'(sys3_err), 32'd0);
        check("rst_sys2", 32'(sys2_err), 32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        reset = 1'b0;
        step();
        check("idle_hold", 32'(chk_state), 32'd0);

        // Vector 0 also pulses run mid-WAIT; vector 2 puts 0xFF one cycle early.
        for (int v = 0; v < 5; v++) begin
            for (int k = 0; k < 12; k++) cur_bytes[k] = vecs[v].b[k];
            e_agree = vecs[v].agree;
            e_s3    = vecs[v].s3;
            e_s2    = vecs[v].s2;
            e_cnt   = vecs[v].cnt;
            do_run(v == 0, v == 2);
        end

        // Reset in the middle of a capture discards it.
        for (int k = 0; k < 12; k++) cur_bytes[k] = vecs[0].b[k];
        run = 1'b1;
        step();
        run = 1'b0;
        for (int i = 1; i <= 113; i++) begin
            display_result = 8'($urandom);
            step();
        end
        for (int k = 0; k < 4; k++) begin
            display_result = cur_bytes[k];
            step();
        end
        check("mid_cap_state", 32'(chk_state), 32'd2);
        reset   = 1'b1;
        rd_addr = 4'd2;
        step();                                   // edge E0+118
        reset = 1'b0;
        check("midrst_state", 32'(chk_state), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_agree", 32'(agree), 32'd0);
        check("midrst_err_count", 32'(err_count), 32'd0);
        step();
        check("midrst_rd2", 32'(rd_data), 32'd0);
        check("midrst_idle", 32'(chk_state), 32'd0);

        for (int k = 0; k < 12; k++) cur_bytes[k] = vecs[1].b[k];
        model();
        do_run(1'b0, 1'b0);

        for (int r = 0; r < 6; r++) begin
            for (int j = 0; j < 4; j++) begin
                logic [7:0] base;
                base             = 8'($urandom);
                cur_bytes[j]     = base;
                cur_bytes[4 + j] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : base;
                cur_bytes[8 + j] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : base;
            end
            model();
            do_run($urandom_range(0, 1) == 1, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
